decode_stage_gen: RTL and testbench
===================================

// Module: decode_stage_gen
// PURPOSE
//  Parametrised decode stage, successor to the fixed 16-bit decode: 8-entry register file, immediate generation,
//  destination select and the ID/EX pipeline register. Adds write-through bypass, load-use hazard detection with
//  bubble insertion, downstream hold, a valid bit and configurable data/control widths. Sits between IF/ID and execute.
// PARAMETERS
//  DWIDTH      16  datapath width (>=16); register file, PCs and immediates are DWIDTH wide
//  CWIDTH      12  width of opaque control bundle carried ID->EX
//  BYPASS      1   1: same-cycle WB write forwarded to decode reads; 0: reads return stored value only
//  LOADUSE_EN  1   1: internal load-use stall detection enabled; 0: id_stall driven only by ex_hold
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset (0 = reset)
//  id_valid    in   1       IF/ID holds a real instruction
//  id_instr    in   16      instruction; rs=[10:8], rt=[7:5], rd=[4:2]
//  id_pc       in   DWIDTH  instruction PC
//  id_pc2      in   DWIDTH  PC+2
//  id_ctrl     in   CWIDTH  control bundle from control unit
//  id_regdst   in   2       00 rt, 01 rd, 10 rs, 11 R7
//  id_imm_sel  in   2       00 [4:0], 01 [7:0], 10 [10:0], 11 illegal
//  id_zext     in   1       1 zero-extend immediate, 0 sign-extend
//  id_rd_use   in   2       [1] reads rs, [0] reads rt (hazard qualification)
//  id_regwrite/id_memread/id_memwrite/id_halt  in 1  instruction side effects
//  wb_we       in   1       register file write enable
//  wb_addr     in   3       write register
//  wb_data     in   DWIDTH  write data
//  ex_hold     in   1       execute cannot accept; freeze ID/EX and IF/ID
//  flush       in   1       taken branch/jump: squash instruction in decode
//  id_stall    out  1       to fetch: hold PC and IF/ID this cycle
//  ex_valid, ex_pc, ex_pc2, ex_rd1, ex_rd2, ex_imm, ex_ctrl, ex_wr_addr(3), ex_rt_addr(3),
//  ex_regwrite, ex_memread, ex_memwrite, ex_halt   out   registered ID/EX fields
//  ex_err      out  1       registered: illegal imm_sel on a valid, unflushed instruction
// BEHAVIOUR
//  - Reset (rst=0, async): all ID/EX outputs 0, register file all 0, id_stall 0 (combinational, follows inputs).
//  - Latency: 1 cycle decode -> ID/EX. Register file write takes effect on the clock edge.
//  - Read: rd1=RF[rs], rd2=RF[rt]. BYPASS=1 and wb_we and wb_addr==rs/rt -> wb_data returned same cycle.
//  - Immediate: field per id_imm_sel, extended to DWIDTH per id_zext; imm_sel=11 -> imm 0, err flagged.
//  - Load-use (LOADUSE_EN=1): lu = id_valid & ex_valid & ex_memread & ex_regwrite &
//    ((id_rd_use[1] & ex_wr_addr==rs) | (id_rd_use[0] & ex_wr_addr==rt)).
//  - id_stall = ex_hold | (lu & ~flush).
//  - Per-edge ID/EX update, priority order:
//      1 ex_hold=1: hold all ID/EX contents (flush during hold is ignored here; fetch keeps the request pending).
//      2 flush=1:   load bubble: ex_valid=0, regwrite/memread/memwrite/halt/err=0; datapath fields don't-care.
//      3 lu=1:      load bubble as above; IF/ID holds via id_stall, instruction re-decodes next cycle.
//      4 else:      load decoded values; side-effect bits = id_* & id_valid; ex_valid=id_valid.
//  - Bubble never sets ex_halt; a halt in decode is killed by flush.
//  - WB write proceeds regardless of hold/flush/stall.
//  - Mid-operation reset: immediate clear; first post-reset cycle decodes normally.
// TESTING
//  1 Reset: rst=0 async -> all ex_* 0 before next edge; RF reads 0 for all 8 regs after release.
//  2 Bypass: wb_we=1,wb_addr=3,wb_data=16'hBEEF, instr rs=3 -> ex_rd1=16'hBEEF next edge; BYPASS=0 -> 0.
//  3 Immediates: instr[10:0]=11'h7F0 sel=10 zext=0 -> ex_imm=16'hFFF0; sel=00 zext=1 instr[4:0]=5'h10 -> 16'h0010; sel=11 -> ex_err=1.
//  4 Load-use: EX load to R2, decode rs=2 use=10 -> id_stall=1, one bubble (ex_valid=0), then instr issues with ex_valid=1.
//  5 Priority: flush with lu -> id_stall=0, bubble; ex_hold=1 for 3 cycles -> ID/EX unchanged, id_stall=1 each cycle.
//  6 Halt squash: id_halt=1 with flush=1 -> ex_halt=0; without flush -> ex_halt=1 after one edge.

Source files
------------

// File: rtl/decode_stage_gen.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_gen
//  Description : Parametrised instruction decode stage. Holds an 8-entry
//                register file and generates immediates. It selects the
//                destination register and drives the ID/EX pipeline register.
//                It also provides write-through bypass, load-use bubble
//                insertion, downstream hold, squash on flush and a valid bit.
//  Ports       :
//    clk, rst                         clock, async active-low reset
//    id_valid/instr/pc/pc2/ctrl       decode-side instruction and metadata
//    id_regdst, id_imm_sel, id_zext   destination / immediate selection
//    id_rd_use                        which source operands are really read
//    id_regwrite/memread/memwrite/halt  side effects of the instruction
//    wb_we, wb_addr, wb_data          register file write port
//    ex_hold, flush                   downstream hold, branch squash
//    id_stall                         to fetch: hold PC and IF/ID
//    ex_*                             registered ID/EX fields
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage_gen #(
  parameter int DWIDTH     = 16,
  parameter int CWIDTH     = 12,
  parameter bit BYPASS     = 1'b1,
  parameter bit LOADUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [DWIDTH-1:0] id_pc2,
  input  logic [CWIDTH-1:0] id_ctrl,
  input  logic [1:0]        id_regdst,
  input  logic [1:0]        id_imm_sel,
  input  logic              id_zext,
  input  logic [1:0]        id_rd_use,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_halt,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [DWIDTH-1:0] ex_pc2,
  output logic [DWIDTH-1:0] ex_rd1,
  output logic [DWIDTH-1:0] ex_rd2,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [CWIDTH-1:0] ex_ctrl,
  output logic [2:0]        ex_wr_addr,
  output logic [2:0]        ex_rt_addr,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_halt,
  output logic              ex_err
);

  typedef struct packed {
    logic              valid;
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] pc2;
    logic [DWIDTH-1:0] rd1;
    logic [DWIDTH-1:0] rd2;
    logic [DWIDTH-1:0] imm;
    logic [CWIDTH-1:0] ctrl;
    logic [2:0]        wr_addr;
    logic [2:0]        rt_addr;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              halt;
    logic              err;
  } idex_t;

  localparam logic [2:0] C_LINK_REG = 3'd7;

  logic [DWIDTH-1:0] rf_q [8];
  logic [DWIDTH-1:0] rf_d [8];
  idex_t             idex_q;
  idex_t             idex_d;
  idex_t             dec;

  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [DWIDTH-1:0] rd1;
  logic [DWIDTH-1:0] rd2;
  logic [DWIDTH-1:0] imm;
  logic              imm_illegal;
  logic [2:0]        wr_addr;
  logic              lu;
  logic              unused_instr_hi;

  assign rs = id_instr[10:8];
  assign rt = id_instr[7:5];
  assign rd = id_instr[4:2];
  assign unused_instr_hi = ^id_instr[15:11];

  // ---------------- register file ----------------
  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Write-through: a write landing this edge is visible to this decode.
  always_comb begin
    rd1 = rf_q[rs];
    rd2 = rf_q[rt];
    if (BYPASS && wb_we && (wb_addr == rs)) rd1 = wb_data;
    if (BYPASS && wb_we && (wb_addr == rt)) rd2 = wb_data;
  end

  // ---------------- immediate generation ----------------
  always_comb begin
    imm         = '0;
    imm_illegal = 1'b0;
    unique case (id_imm_sel)
      2'b00: imm = id_zext ? {{(DWIDTH-5){1'b0}}, id_instr[4:0]}
                           : {{(DWIDTH-5){id_instr[4]}}, id_instr[4:0]};
      2'b01: imm = id_zext ? {{(DWIDTH-8){1'b0}}, id_instr[7:0]}
                           : {{(DWIDTH-8){id_instr[7]}}, id_instr[7:0]};
      2'b10: imm = id_zext ? {{(DWIDTH-11){1'b0}}, id_instr[10:0]}
                           : {{(DWIDTH-11){id_instr[10]}}, id_instr[10:0]};
      default: imm_illegal = 1'b1;
    endcase
  end

  // ---------------- destination select ----------------
  always_comb begin
    wr_addr = rt;
    unique case (id_regdst)
      2'b00:   wr_addr = rt;
      2'b01:   wr_addr = rd;
      2'b10:   wr_addr = rs;
      default: wr_addr = C_LINK_REG;
    endcase
  end

  // ---------------- load-use detection ----------------
  // The load in EX has not produced data yet; only operands the decoding
  // instruction really reads (id_rd_use) can create a hazard.
  generate
    if (LOADUSE_EN) begin : g_lu_on
      assign lu = id_valid & idex_q.valid & idex_q.memread & idex_q.regwrite &
                  ((id_rd_use[1] & (idex_q.wr_addr == rs)) |
                   (id_rd_use[0] & (idex_q.wr_addr == rt)));
    end else begin : g_lu_off
      assign lu = 1'b0;
    end
  endgenerate

  // A flush discards the decoding instruction, so a hazard on it is moot.
  assign id_stall = ex_hold | (lu & ~flush);

  // ---------------- ID/EX next state ----------------
  always_comb begin
    dec          = '0;
    dec.valid    = id_valid;
    dec.pc       = id_pc;
    dec.pc2      = id_pc2;
    dec.rd1      = rd1;
    dec.rd2      = rd2;
    dec.imm      = imm;
    dec.ctrl     = id_ctrl;
    dec.wr_addr  = wr_addr;
    dec.rt_addr  = rt;
    dec.regwrite = id_regwrite & id_valid;
    dec.memread  = id_memread  & id_valid;
    dec.memwrite = id_memwrite & id_valid;
    dec.halt     = id_halt     & id_valid;
    dec.err      = imm_illegal & id_valid;
  end

  always_comb begin
    idex_d = idex_q;
    if (!ex_hold) begin
      idex_d = dec;
      // Bubble: datapath fields are don't-care, only qualifiers are cleared.
      if (flush || lu) begin
        idex_d.valid    = 1'b0;
        idex_d.regwrite = 1'b0;
        idex_d.memread  = 1'b0;
        idex_d.memwrite = 1'b0;
        idex_d.halt     = 1'b0;
        idex_d.err      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_pc2      = idex_q.pc2;
  assign ex_rd1      = idex_q.rd1;
  assign ex_rd2      = idex_q.rd2;
  assign ex_imm      = idex_q.imm;
  assign ex_ctrl     = idex_q.ctrl;
  assign ex_wr_addr  = idex_q.wr_addr;
  assign ex_rt_addr  = idex_q.rt_addr;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_halt     = idex_q.halt;
  assign ex_err      = idex_q.err;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_gen
//  Description : Self-checking bench for decode_stage_gen. Instance A uses
//                bypass and load-use detection; instance B has both disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage_gen;
  localparam int DW = 16;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [15:0]   id_instr;
  logic [DW-1:0] id_pc, id_pc2;
  logic [CW-1:0] id_ctrl;
  logic [1:0]    id_regdst, id_imm_sel, id_rd_use;
  logic          id_zext, id_regwrite, id_memread, id_memwrite, id_halt;
  logic          wb_we;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_hold, flush;

  logic          stall_a, valid_a, rw_a, mr_a, mw_a, halt_a, err_a;
  logic [DW-1:0] pc_a, pc2_a, rd1_a, rd2_a, imm_a;
  logic [CW-1:0] ctrl_a;
  logic [2:0]    wr_a, rt_a;
  logic          stall_b, valid_b, rw_b, mr_b, mw_b, halt_b, err_b;
  logic [DW-1:0] pc_b, pc2_b, rd1_b, rd2_b, imm_b;
  logic [CW-1:0] ctrl_b;
  logic [2:0]    wr_b, rt_b;

  always #5 clk = ~clk;

  decode_stage_gen #(.DWIDTH(DW), .CWIDTH(CW), .BYPASS(1'b1), .LOADUSE_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc2(id_pc2), .id_ctrl(id_ctrl), .id_regdst(id_regdst), .id_imm_sel(id_imm_sel),
    .id_zext(id_zext), .id_rd_use(id_rd_use), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_halt(id_halt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
    .id_stall(stall_a), .ex_valid(valid_a), .ex_pc(pc_a), .ex_pc2(pc2_a), .ex_rd1(rd1_a),
    .ex_rd2(rd2_a), .ex_imm(imm_a), .ex_ctrl(ctrl_a), .ex_wr_addr(wr_a), .ex_rt_addr(rt_a),
    .ex_regwrite(rw_a), .ex_memread(mr_a), .ex_memwrite(mw_a), .ex_halt(halt_a), .ex_err(err_a));

  decode_stage_gen #(.DWIDTH(DW), .CWIDTH(CW), .BYPASS(1'b0), .LOADUSE_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc2(id_pc2), .id_ctrl(id_ctrl), .id_regdst(id_regdst), .id_imm_sel(id_imm_sel),
    .id_zext(id_zext), .id_rd_use(id_rd_use), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_halt(id_halt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
    .id_stall(stall_b), .ex_valid(valid_b), .ex_pc(pc_b), .ex_pc2(pc2_b), .ex_rd1(rd1_b),
    .ex_rd2(rd2_b), .ex_imm(imm_b), .ex_ctrl(ctrl_b), .ex_wr_addr(wr_b), .ex_rt_addr(rt_b),
    .ex_regwrite(rw_b), .ex_memread(mr_b), .ex_memwrite(mw_b), .ex_halt(halt_b), .ex_err(err_b));

  typedef struct {
    logic          valid;
    logic [DW-1:0] pc, pc2, rd1, rd2, imm;
    logic [CW-1:0] ctrl;
    logic [2:0]    wr, rt;
    logic          regwrite, memread, memwrite, halt, err;
  } stage_t;

  stage_t        m [2];
  logic [DW-1:0] mrf [2][8];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          last_stall [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stage_t obs_of(input int k);
    stage_t s;
    if (k == 0) begin
      s.valid = valid_a; s.pc = pc_a; s.pc2 = pc2_a; s.rd1 = rd1_a; s.rd2 = rd2_a;
      s.imm = imm_a; s.ctrl = ctrl_a; s.wr = wr_a; s.rt = rt_a; s.regwrite = rw_a;
      s.memread = mr_a; s.memwrite = mw_a; s.halt = halt_a; s.err = err_a;
    end else begin
      s.valid = valid_b; s.pc = pc_b; s.pc2 = pc2_b; s.rd1 = rd1_b; s.rd2 = rd2_b;
      s.imm = imm_b; s.ctrl = ctrl_b; s.wr = wr_b; s.rt = rt_b; s.regwrite = rw_b;
      s.memread = mr_b; s.memwrite = mw_b; s.halt = halt_b; s.err = err_b;
    end
    return s;
  endfunction

  task automatic compare_all(input int k);
    stage_t o = obs_of(k);
    string  p = (k == 0) ? "A." : "B.";
    check({p, "valid"},    32'(o.valid),    32'(m[k].valid));
    check({p, "regwrite"}, 32'(o.regwrite), 32'(m[k].regwrite));
    check({p, "memread"},  32'(o.memread),  32'(m[k].memread));
    check({p, "memwrite"}, 32'(o.memwrite), 32'(m[k].memwrite));
    check({p, "halt"},     32'(o.halt),     32'(m[k].halt));
    check({p, "err"},      32'(o.err),      32'(m[k].err));
    // Datapath fields of a bubble are don't-care.
    if (m[k].valid) begin
      check({p, "pc"},   32'(o.pc),   32'(m[k].pc));
      check({p, "pc2"},  32'(o.pc2),  32'(m[k].pc2));
      check({p, "rd1"},  32'(o.rd1),  32'(m[k].rd1));
      check({p, "rd2"},  32'(o.rd2),  32'(m[k].rd2));
      check({p, "imm"},  32'(o.imm),  32'(m[k].imm));
      check({p, "ctrl"}, 32'(o.ctrl), 32'(m[k].ctrl));
      check({p, "wr"},   32'(o.wr),   32'(m[k].wr));
      check({p, "rt"},   32'(o.rt),   32'(m[k].rt));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k] = '{default: '0};
      for (int r = 0; r < 8; r++) mrf[k][r] = '0;
    end
  endtask

  // Immediate as an integer: take the field, optionally reinterpret as signed.
  function automatic logic [DW-1:0] model_imm();
    int w;
    int v;
    case (id_imm_sel)
      2'd0:    w = 5;
      2'd1:    w = 8;
      2'd2:    w = 11;
      default: return '0;
    endcase
    v = int'(id_instr) % (1 << w);
    if (!id_zext && v >= (1 << (w - 1))) v = v - (1 << w);
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_read(input int k, input int a);
    if (k == 0 && wb_we && int'(wb_addr) == a) return wb_data;
    return mrf[k][a];
  endfunction

  function automatic bit model_lu(input int k);
    int rs = int'(id_instr[10:8]);
    int rt = int'(id_instr[7:5]);
    if (k == 1) return 1'b0;
    return id_valid && m[k].valid && m[k].memread && m[k].regwrite &&
           ((id_rd_use[1] && int'(m[k].wr) == rs) || (id_rd_use[0] && int'(m[k].wr) == rt));
  endfunction

  task automatic model_edge(input int k);
    stage_t n = m[k];
    int     rs = int'(id_instr[10:8]);
    int     rt = int'(id_instr[7:5]);
    int     rd = int'(id_instr[4:2]);
    if (!ex_hold) begin
      n = '{default: '0};
      if (!(flush || model_lu(k))) begin
        n.valid = id_valid; n.pc = id_pc; n.pc2 = id_pc2;
        n.rd1 = model_read(k, rs); n.rd2 = model_read(k, rt);
        n.imm = model_imm(); n.ctrl = id_ctrl;
        n.wr = (id_regdst == 2'd0) ? 3'(rt) : (id_regdst == 2'd1) ? 3'(rd) :
               (id_regdst == 2'd2) ? 3'(rs) : 3'd7;
        n.rt = 3'(rt);
        n.regwrite = id_valid & id_regwrite; n.memread = id_valid & id_memread;
        n.memwrite = id_valid & id_memwrite; n.halt = id_valid & id_halt;
        n.err = id_valid & (id_imm_sel == 2'd3);
      end
    end
    if (wb_we) mrf[k][wb_addr] = wb_data;
    m[k] = n;
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic cycle();
    #2;
    last_stall[0] = stall_a;
    last_stall[1] = stall_b;
    check("A.id_stall", 32'(stall_a), 32'(ex_hold | (model_lu(0) & ~flush)));
    check("B.id_stall", 32'(stall_b), 32'(ex_hold));
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  task automatic idle();
    id_valid = 0; id_instr = '0; id_pc = '0; id_pc2 = '0; id_ctrl = '0;
    id_regdst = '0; id_imm_sel = '0; id_zext = 0; id_rd_use = '0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_halt = 0;
    wb_we = 0; wb_addr = '0; wb_data = '0; ex_hold = 0; flush = 0;
  endtask

  task automatic load_r2_into_ex();
    idle();
    id_valid = 1; id_regwrite = 1; id_memread = 1; id_regdst = 2'b01;
    id_instr = 16'h0008;                       // rd = 2
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #2;
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Put some state in, then reset mid-cycle.
    for (int i = 0; i < 6; i++) begin
      idle();
      id_valid = 1; id_instr = 16'($urandom); id_pc = 16'($urandom);
      wb_we = 1; wb_addr = 3'(i); wb_data = 16'($urandom | 1);
      id_regwrite = 1;
      cycle();
    end
    rst = 1'b0;
    #1;
    model_reset();
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();

    for (int r = 0; r < 8; r++) begin
      idle();
      id_valid = 1;
      id_instr = {5'd0, 3'(r), 3'(7 - r), 5'd0};
      cycle();
      check("rf_zero_rd1", 32'(rd1_a), 32'h0);
      check("rf_zero_rd2", 32'(rd2_a), 32'h0);
    end

    idle();
    id_valid = 1; wb_we = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    id_instr = 16'h0300;
    cycle();
    check("bypass_on", 32'(rd1_a), 32'hBEEF);
    check("bypass_off", 32'(rd1_b), 32'h0);

    idle();
    id_valid = 1; id_instr = {5'd0, 11'h7F0}; id_imm_sel = 2'b10; id_zext = 0;
    cycle();
    check("imm_sext11", 32'(imm_a), 32'hFFF0);
    idle();
    id_valid = 1; id_instr = 16'h0010; id_imm_sel = 2'b00; id_zext = 1;
    cycle();
    check("imm_zext5", 32'(imm_a), 32'h0010);
    idle();
    id_valid = 1; id_instr = 16'h0555; id_imm_sel = 2'b11;
    cycle();
    check("imm_illegal_err", 32'(err_a), 32'h1);
    check("imm_illegal_val", 32'(imm_a), 32'h0);

    load_r2_into_ex();
    idle();
    id_valid = 1; id_instr = 16'h0200; id_rd_use = 2'b10;
    cycle();
    check("lu_stall", 32'(last_stall[0]), 32'h1);
    check("lu_bubble", 32'(valid_a), 32'h0);
    check("lu_off_issue", 32'(valid_b), 32'h1);
    cycle();
    check("lu_reissue", 32'(valid_a), 32'h1);

    load_r2_into_ex();
    idle();
    id_valid = 1; id_instr = 16'h0200; id_rd_use = 2'b10; flush = 1;
    cycle();
    check("flush_lu_stall", 32'(last_stall[0]), 32'h0);
    check("flush_bubble", 32'(valid_a), 32'h0);

    idle();
    id_valid = 1; id_pc = 16'h1234; id_regwrite = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      id_valid = 1; id_pc = 16'h5678; ex_hold = 1; flush = (i == 1);
      cycle();
      check("hold_stall", 32'(last_stall[0]), 32'h1);
      check("hold_pc", 32'(pc_a), 32'h1234);
      check("hold_valid", 32'(valid_a), 32'h1);
    end

    idle();
    id_valid = 1; id_halt = 1; flush = 1;
    cycle();
    check("halt_squash", 32'(halt_a), 32'h0);
    flush = 0;
    cycle();
    check("halt_issue", 32'(halt_a), 32'h1);

    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_instr    = 16'($urandom);
      id_pc       = 16'($urandom);
      id_pc2      = 16'($urandom);
      id_ctrl     = 12'($urandom);
      id_regdst   = 2'($urandom);
      id_imm_sel  = 2'($urandom);
      id_zext     = 1'($urandom);
      id_rd_use   = 2'($urandom);
      id_regwrite = 1'($urandom);
      id_memread  = 1'($urandom);
      id_memwrite = 1'($urandom);
      id_halt     = ($urandom_range(0, 7) == 0);
      wb_we       = 1'($urandom);
      wb_addr     = 3'($urandom);
      wb_data     = 16'($urandom);
      ex_hold     = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
